// File: rtl/bp_fifo_pkg.sv
// Shared BytePipe definitions used by the byte FIFO and its storage array.
package bp_fifo_pkg;
  localparam int unsigned BP_W = 8;
endpackage

// File: rtl/bp_fifo_mem.sv
// DEPTH x BP_W storage: one synchronous write port, one asynchronous read port, no reset.
module bp_fifo_mem
  import bp_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [BP_W-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output logic [BP_W-1:0] o_rdata
);

  logic [BP_W-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/bp_fifo.sv
// Byte FIFO between the USB byte stream and the BytePipe stage; valid/ready on both sides.
module bp_fifo
  import bp_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_cg,
  input  logic            i_flush,
  input  logic [BP_W-1:0] i_bp_data,
  input  logic            i_bp_valid,
  output logic            o_bp_ready,
  output logic [BP_W-1:0] o_bp_data,
  output logic            o_bp_valid,
  input  logic            i_bp_ready,
  output logic [PTR_W:0]  o_nEntries,
  output logic            o_full,
  output logic            o_empty
);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || PTR_W != $clog2(DEPTH)) begin : g_bad_depth
    $error("bp_fifo: DEPTH must be a power of 2 in 2..256 and PTR_W must not be overridden");
  end

  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           push, pop;

  assign o_full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign o_empty    = (wr_ptr_q == rd_ptr_q);
  assign o_nEntries = wr_ptr_q - rd_ptr_q;

  // Handshakes are qualified with reset so nothing is offered while reset is held.
  assign o_bp_ready = i_cg && !o_full  && !i_rst;
  assign o_bp_valid = i_cg && !o_empty && !i_rst;

  assign push = i_bp_valid && o_bp_ready;
  assign pop  = o_bp_valid && i_bp_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_cg && i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  bp_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push && !i_flush),
    .i_waddr (wr_ptr_q[PTR_W-1:0]),
    .i_wdata (i_bp_data),
    .i_raddr (rd_ptr_q[PTR_W-1:0]),
    .o_rdata (o_bp_data)
  );

endmodule

// File: tb/tb_bp_fifo.sv
// Directed and random checks of bp_fifo (DEPTH=4) against a queue-based reference model.
module tb_bp_fifo;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, cg, flush;
  logic [7:0] wdata;
  logic       wvalid, wready;
  logic [7:0] rdata;
  logic       rvalid, rready;
  logic [2:0] n_ent;
  logic       full, empty;

  int n_vec = 0;
  int n_err = 0;

  bp_fifo #(.DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_cg       (cg),
    .i_flush    (flush),
    .i_bp_data  (wdata),
    .i_bp_valid (wvalid),
    .o_bp_ready (wready),
    .o_bp_data  (rdata),
    .o_bp_valid (rvalid),
    .i_bp_ready (rready),
    .o_nEntries (n_ent),
    .o_full     (full),
    .o_empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored bytes, updated from the inputs seen at each edge.
  byte unsigned q[$];
  bit m_pop, m_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else if (cg) begin
      if (flush) begin
        q.delete();
      end else begin
        m_pop  = (q.size() > 0) && rready;
        m_push = wvalid && (q.size() < DEPTH);
        if (m_pop) void'(q.pop_front());
        if (m_push) q.push_back(wdata);
      end
    end
  end

  always @(negedge clk) begin
    chk("m_nEntries", {29'd0, n_ent}, q.size());
    chk("m_empty", {31'd0, empty}, q.size() == 0);
    chk("m_full", {31'd0, full}, q.size() == DEPTH);
    chk("m_ready", {31'd0, wready}, cg && !rst && q.size() < DEPTH);
    chk("m_valid", {31'd0, rvalid}, cg && !rst && q.size() > 0);
    if (cg && !rst && q.size() > 0) chk("m_data", {24'd0, rdata}, q[0]);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] b);
    wvalid = 1'b1;
    wdata  = b;
    cyc();
    wvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cg = 1'b1; flush = 1'b0;
    wdata = '0; wvalid = 1'b0; rready = 1'b0;
    repeat (2) cyc();
    chk("rst_valid", {31'd0, rvalid}, 0);
    chk("rst_ready", {31'd0, wready}, 0);
    chk("rst_n", {29'd0, n_ent}, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, wready}, 1);
    chk("post_rst_valid", {31'd0, rvalid}, 0);
    cyc();

    // Fill to full, then offer a fifth byte that must be held off.
    push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
    chk("fill_full", {31'd0, full}, 1);
    chk("fill_n", {29'd0, n_ent}, 4);
    chk("fill_ready", {31'd0, wready}, 0);
    push1(8'h55);
    chk("held_n", {29'd0, n_ent}, 4);
    chk("held_head", {24'd0, rdata}, 8'h11);

    rready = 1'b1;
    chk("drain0", {24'd0, rdata}, 8'h11); cyc();
    chk("drain1", {24'd0, rdata}, 8'h22); cyc();
    chk("drain2", {24'd0, rdata}, 8'h33); cyc();
    chk("drain3", {24'd0, rdata}, 8'h44); cyc();
    rready = 1'b0;
    chk("drain_empty", {31'd0, empty}, 1);
    chk("drain_valid", {31'd0, rvalid}, 0);

    // One-cycle latency from empty, no bypass.
    wvalid = 1'b1; wdata = 8'h77;
    #1;
    chk("nobypass_valid", {31'd0, rvalid}, 0);
    cyc();
    wvalid = 1'b0;
    chk("lat_valid", {31'd0, rvalid}, 1);
    chk("lat_data", {24'd0, rdata}, 8'h77);
    rready = 1'b1; cyc(); rready = 1'b0;

    // Streaming push+pop across pointer wrap.
    rready = 1'b1;
    push1(8'h00);
    wvalid = 1'b1;
    for (int i = 1; i < 20; i++) begin
      chk("stream_n", {29'd0, n_ent}, 1);
      chk("stream_data", {24'd0, rdata}, i - 1);
      wdata = 8'(i);
      cyc();
    end
    wvalid = 1'b0;
    chk("stream_last", {24'd0, rdata}, 8'h13);
    cyc();
    rready = 1'b0;
    chk("stream_empty", {31'd0, empty}, 1);

    // Flush beats a simultaneous push.
    push1(8'hA1); push1(8'hA2); push1(8'hA3);
    chk("pre_flush_n", {29'd0, n_ent}, 3);
    flush = 1'b1; wvalid = 1'b1; wdata = 8'hAA;
    cyc();
    flush = 1'b0; wvalid = 1'b0;
    chk("flush_n", {29'd0, n_ent}, 0);
    chk("flush_valid", {31'd0, rvalid}, 0);
    push1(8'h3C);
    chk("post_flush_data", {24'd0, rdata}, 8'h3C);
    rready = 1'b1; cyc(); rready = 1'b0;

    // Asynchronous reset between edges.
    push1(8'hB1); push1(8'hB2);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, rvalid}, 0);
    chk("arst_n", {29'd0, n_ent}, 0);
    chk("arst_empty", {31'd0, empty}, 1);
    cyc(); cyc();
    rst = 1'b0;
    push1(8'h5A);
    chk("arst_after_valid", {31'd0, rvalid}, 1);
    chk("arst_after_data", {24'd0, rdata}, 8'h5A);
    rready = 1'b1; cyc(); rready = 1'b0;

    // Clock-gate freeze with both handshakes requested.
    push1(8'h01); push1(8'h02);
    cg = 1'b0; wvalid = 1'b1; rready = 1'b1; wdata = 8'h99;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("cg_ready", {31'd0, wready}, 0);
      chk("cg_valid", {31'd0, rvalid}, 0);
      chk("cg_n", {29'd0, n_ent}, 2);
      cyc();
    end
    cg = 1'b1; wvalid = 1'b0; rready = 1'b0;
    #1;
    chk("cg_resume_data", {24'd0, rdata}, 8'h01);
    chk("cg_resume_n", {29'd0, n_ent}, 2);

    // Random soak; the negedge compare process checks every cycle.
    for (int i = 0; i < 400; i++) begin
      wvalid = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 2) != 0);
      wdata  = 8'($urandom);
      flush  = ($urandom_range(0, 31) == 0);
      cg     = ($urandom_range(0, 15) != 0);
      cyc();
    end
    cg = 1'b1; flush = 1'b0; wvalid = 1'b0; rready = 1'b1;
    repeat (6) cyc();
    chk("soak_empty", {31'd0, empty}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bp_fifo.md
BP_FIFO -- requirements
Module: bp_fifo

Byte FIFO placed between the USB byte stream and the register-access BytePipe stage, on either direction.

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; a power of 2 in {2..256}.
REQ-002 Parameter PTR_W, default $clog2(DEPTH), derived; overriding it is not permitted.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset; asynchronous, active-high.
REQ-005 i_cg  input  1  clock-gate enable; 0 freezes all state.
REQ-006 i_flush  input  1  synchronous discard of all stored bytes.
REQ-007 i_bp_data  input  8  write-side byte.
REQ-008 i_bp_valid  input  1  write-side valid.
REQ-009 o_bp_ready  output  1  write-side ready.
REQ-010 o_bp_data  output  8  read-side byte, the oldest stored entry.
REQ-011 o_bp_valid  output  1  read-side valid.
REQ-012 i_bp_ready  input  1  read-side ready.
REQ-013 o_nEntries  output  PTR_W+1  current occupancy, 0..DEPTH.
REQ-014 o_full / o_empty  output  1 each  occupancy == DEPTH / occupancy == 0.

Function
REQ-015 Push: occurs when i_bp_valid && o_bp_ready; pop: occurs when o_bp_valid && i_bp_ready.
REQ-016 o_bp_ready = i_cg && !o_full && !i_rst; no pass-through when full, even if a pop occurs in the same cycle.
REQ-017 o_bp_valid = i_cg && !o_empty && !i_rst; o_bp_data = memory[rdPtr], combinational from registered state.
REQ-018 Latency: a byte pushed in cycle N is presented with o_bp_valid=1 in cycle N+1 if the FIFO was empty; there is no zero-cycle bypass.
REQ-019 Pointers: wrPtr and rdPtr are PTR_W+1 bits; each increments modulo 2^(PTR_W+1) on push or pop respectively; memory index = ptr[PTR_W-1:0].
REQ-020 Occupancy: o_nEntries = wrPtr - rdPtr, PTR_W+1-bit unsigned; full when MSBs differ and low bits are equal; empty when the pointers are equal.
REQ-021 Simultaneous push and pop when 0 < occupancy < DEPTH: both pointers advance and occupancy is unchanged.
REQ-022 Simultaneous push and pop when empty: impossible, since o_bp_valid=0; only the push takes effect.
REQ-023 Simultaneous push and pop when full: impossible, since o_bp_ready=0; only the pop takes effect.
REQ-024 Ordering: bytes are popped in exact push order, with no loss or duplication across pointer wrap-around.
REQ-025 Flush: when i_flush=1 and i_cg=1, both pointers are set to 0 on the next edge; flush has priority over any same-cycle push or pop, and that push is discarded.
REQ-026 i_cg=0: pointers and memory hold, and both handshakes are forced inactive per REQ-016/017.
REQ-027 Memory writes only on push; memory contents are never read when empty.

Reset
REQ-028 While i_rst=1: wrPtr=rdPtr=0, o_bp_valid=0, o_bp_ready=0, o_nEntries=0, o_empty=1, o_full=0.
REQ-029 Assertion mid-operation discards all stored bytes immediately (asynchronously); memory contents are not reset and are don't-care.
REQ-030 First cycle after deassertion with i_cg=1: o_bp_ready=1, o_bp_valid=0.

Structure
REQ-031 The BytePipe byte width constant (8) belongs in the shared BytePipe package; no typedefs are required.
REQ-032 The storage array is a separate sub-module, bp_fifo_mem: DEPTH x 8, one synchronous write port, one asynchronous read port, no reset.
REQ-033 Pointer and occupancy logic stays in bp_fifo; the DEPTH legality check is an elaboration-time assertion.

Verification
REQ-034 DEPTH=4; push 0x11,0x22,0x33,0x44 with i_bp_ready=0 -> o_full=1, o_nEntries=4, o_bp_ready=0; fifth byte 0x55 held off.
REQ-035 From full, i_bp_ready=1 for 4 cycles -> pops 0x11,0x22,0x33,0x44 in order, then o_empty=1, o_bp_valid=0.
REQ-036 Push to empty at cycle N -> o_bp_valid=1 at N+1 with that byte; continuous push+pop for 20 bytes 0x00..0x13 -> o_nEntries stays 1 and all bytes return in order across the wrap.
REQ-037 Occupancy 3, i_flush=1 with a simultaneous push of 0xAA -> next cycle o_nEntries=0, o_bp_valid=0, and 0xAA is never output.
REQ-038 Occupancy 2, assert i_rst asynchronously between edges -> o_bp_valid=0 and o_nEntries=0 without waiting for a clock edge; after release, push 0x5A -> 0x5A is output.
REQ-039 i_cg=0 for 5 cycles with i_bp_valid=1 and i_bp_ready=1 -> no handshake and no state change; random push/pop soak against a reference queue -> zero mismatches.
